dac_spi_tx: RTL and testbench

- SPI transmitter for the MAX5134 DAC. Consumes one 24-bit command word ({8-bit command, 16-bit data}) per single-cycle send request from the waveform sequencer.
- Serialises the word MSB-first with framed chip-select and a busy/done handshake.
- Sits directly downstream of the sample sequencer and drives the board SPI pins. Clocked from the 133 MHz internal oscillator.

---
 rtl/dac_spi_tx_if.sv | 10 +
 rtl/dac_spi_tx.sv | 93 +++++++++
 tb/tb_dac_spi_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dac_spi_tx_if.sv
// dac_spi_tx_if: sequencer-side handshake plus the MAX5134 SPI pins driven by dac_spi_tx.
interface dac_spi_tx_if #(parameter int WORD_BITS = 24);
    logic [WORD_BITS-1:0] data_in;
    logic send, busy, done, overrun;
    logic spi_cs_out, spi_clock_out, spi_data_out;
    modport master (output data_in, send,
                    input busy, done, overrun, spi_cs_out, spi_clock_out, spi_data_out);
    modport slave (input data_in, send,
                   output busy, done, overrun, spi_cs_out, spi_clock_out, spi_data_out);
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises one {command, data} word per send request to the MAX5134 DAC, MSB first.
module dac_spi_tx #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 24,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_IDLE   = 2
) (
    input logic       clock_in,
    input logic       reset,
    dac_spi_tx_if.slave bus
);
    localparam int M1 = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
    localparam int M2 = CS_HOLD > CS_IDLE ? CS_HOLD : CS_IDLE;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
    localparam int BW = $clog2(WORD_BITS);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, len_m1;
    logic [BW-1:0] bit_q, bit_d;
    logic [WORD_BITS-1:0] sr_q, sr_d;
    logic busy_q, done_q, ovr_q, cs_q, sclk_q, sdo_q;
    logic last, active;
    always_comb begin
        len_m1 = state_q == SETUP ? CW'(CS_SETUP - 1) :
                 state_q == HOLD  ? CW'(CS_HOLD - 1)  :
                 state_q == GAP   ? CW'(CS_IDLE - 1)  : CW'(CLK_DIV - 1);
        last = cnt_q == len_m1;
        state_d = state_q;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        sr_d = sr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.send) begin
                    state_d = SETUP;
                    sr_d = bus.data_in;
                    bit_d = BW'(WORD_BITS - 1);
                end
            end
            SETUP: if (last) state_d = SHIFT_LO;
            // the rising SCLK edge launches the next bit; bit 0 stays on the line through HOLD
            SHIFT_LO: if (last) begin
                state_d = SHIFT_HI;
                if (bit_q != '0) sr_d = sr_q << 1;
            end
            SHIFT_HI: if (last) begin
                if (bit_q == '0) state_d = HOLD;
                else begin
                    state_d = SHIFT_LO;
                    bit_d = bit_q - 1'b1;
                end
            end
            HOLD: if (last) state_d = GAP;
            GAP: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        active = state_d == SETUP || state_d == SHIFT_LO || state_d == SHIFT_HI || state_d == HOLD;
    end
    // outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sr_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovr_q <= 1'b0;
            cs_q <= 1'b1;
            sclk_q <= 1'b1;
            sdo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sr_q <= sr_d;
            busy_q <= state_d != IDLE;
            done_q <= state_q == HOLD && state_d == GAP;
            ovr_q <= bus.send && busy_q;
            cs_q <= !active;
            sclk_q <= state_d != SHIFT_LO;
            sdo_q <= active && sr_d[WORD_BITS-1];
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.overrun = ovr_q;
    assign bus.spi_cs_out = cs_q;
    assign bus.spi_clock_out = sclk_q;
    assign bus.spi_data_out = sdo_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed frames against a default and a minimum-timing dac_spi_tx.
module tb_dac_spi_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc, cs_low, falls, dones, done_cyc, ovrs, ovr_first, starts, last_start;
    int rise_cyc, gap, idle_cyc, busys, sdo_hi, fall_cyc, fall_per;
    logic [23:0] word;
    logic p_sclk, p_cs;

    dac_spi_tx_if b1 ();
    dac_spi_tx_if b2 ();
    dac_spi_tx dut (.clock_in(clk), .reset(rst), .bus(b1.slave));
    dac_spi_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut2 (.clock_in(clk), .reset(rst), .bus(b2.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic [23:0] d);
        if (sel) begin
            b2.send = s;
            b2.data_in = d;
        end else begin
            b1.send = s;
            b1.data_in = d;
        end
    endtask

    task automatic clear();
        cyc = 0; cs_low = 0; falls = 0; dones = 0; done_cyc = -1; ovrs = 0; ovr_first = -1;
        starts = 0; last_start = -1; rise_cyc = -1; gap = -1; idle_cyc = -1; busys = 0;
        sdo_hi = 0; fall_cyc = -1; fall_per = -1; word = '0; p_sclk = 1'b1; p_cs = 1'b1;
    endtask

    // step n cycles observing one DUT; send is high on cycles < hold and on cycle extra
    task automatic observe(input bit sel, input int n, input int hold, input int extra,
                           input logic [23:0] alt, input int stop_falls);
        logic cs, sck, sdo, dn, ov, bz;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            cs = sel ? b2.spi_cs_out : b1.spi_cs_out;
            sck = sel ? b2.spi_clock_out : b1.spi_clock_out;
            sdo = sel ? b2.spi_data_out : b1.spi_data_out;
            dn = sel ? b2.done : b1.done;
            ov = sel ? b2.overrun : b1.overrun;
            bz = sel ? b2.busy : b1.busy;
            if (!cs) cs_low++;
            if (cs && sdo) sdo_hi++;
            if (bz) busys++;
            if (!bz && idle_cyc < 0) idle_cyc = cyc;
            if (p_sclk && !sck) begin
                falls++;
                word = {word[22:0], sdo};
                if (fall_cyc >= 0) fall_per = cyc - fall_cyc;
                fall_cyc = cyc;
            end
            if (dn) begin dones++; done_cyc = cyc; end
            if (ov) begin ovrs++; if (ovr_first < 0) ovr_first = cyc; end
            if (!p_cs && cs) rise_cyc = cyc;
            if (p_cs && !cs) begin
                starts++;
                last_start = cyc;
                if (rise_cyc >= 0) gap = cyc - rise_cyc;
            end
            p_sclk = sck;
            p_cs = cs;
            drive(sel, cyc < hold || cyc == extra, alt);
            if (falls == stop_falls) break;
        end
    endtask

    initial begin
        drive(0, 0, '0);
        drive(1, 0, '0);
        repeat (5) @(negedge clk);
        chk("rst_cs", b1.spi_cs_out, 1);
        chk("rst_sclk", b1.spi_clock_out, 1);
        chk("rst_sdo", b1.spi_data_out, 0);
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_ovr", b1.overrun, 0);
        rst = 1'b0;
        clear();
        observe(0, 50, 0, -1, 24'h0, -1);
        chk("idle_cs_low", cs_low, 0);
        chk("idle_falls", falls, 0);
        chk("idle_busy", busys, 0);
        chk("idle_sdo", sdo_hi, 0);
        chk("idle_done", dones, 0);

        clear();
        drive(0, 1, 24'h31A5C3);
        observe(0, 260, 1, -1, 24'h0F0F0F, -1);
        chk("one_cs_low", cs_low, 196);
        chk("one_falls", falls, 24);
        chk("one_word", word, 24'h31A5C3);
        chk("one_sclk_per", fall_per, 8);
        chk("one_dones", dones, 1);
        chk("one_done_cyc", done_cyc, 197);
        chk("one_idle_cyc", idle_cyc, 199);
        chk("one_busys", busys, 198);
        chk("one_ovr", ovrs, 0);
        chk("one_sdo_idle", sdo_hi, 0);

        clear();
        drive(0, 1, 24'h310040);
        observe(0, 260, 1, 50, 24'h31FFFF, -1);
        chk("ovr_count", ovrs, 1);
        chk("ovr_cyc", ovr_first, 51);
        chk("ovr_word", word, 24'h310040);
        chk("ovr_starts", starts, 1);
        chk("ovr_dones", dones, 1);

        clear();
        drive(0, 1, 24'h311234);
        observe(0, 650, 450, -1, 24'h311234, -1);
        chk("held_starts", starts, 3);
        chk("held_last_start", last_start, 399);
        chk("held_gap", gap, 3);
        chk("held_dones", dones, 3);
        chk("held_done_cyc", done_cyc, 595);
        chk("held_ovrs", ovrs, 447);
        chk("held_ovr_first", ovr_first, 2);
        chk("held_falls", falls, 72);
        chk("held_word", word, 24'h311234);

        clear();
        drive(0, 1, 24'h31A5C3);
        observe(0, 300, 1, -1, 24'h31A5C3, 10);
        chk("mid_falls", falls, 10);
        rst = 1'b1;
        #1;
        chk("mid_cs", b1.spi_cs_out, 1);
        chk("mid_sclk", b1.spi_clock_out, 1);
        chk("mid_sdo", b1.spi_data_out, 0);
        chk("mid_busy", b1.busy, 0);
        clear();
        observe(0, 3, 0, -1, 24'h0, -1);
        rst = 1'b0;
        observe(0, 10, 0, -1, 24'h0, -1);
        chk("mid_no_done", dones, 0);
        chk("mid_cs_idle", cs_low, 0);
        clear();
        drive(0, 1, 24'hA55A3C);
        observe(0, 260, 1, -1, 24'h0, -1);
        chk("post_word", word, 24'hA55A3C);
        chk("post_falls", falls, 24);
        chk("post_cs_low", cs_low, 196);
        chk("post_dones", dones, 1);

        clear();
        drive(1, 1, 24'hFF0001);
        observe(1, 80, 1, -1, 24'h0, -1);
        chk("min_cs_low", cs_low, 50);
        chk("min_falls", falls, 24);
        chk("min_word", word, 24'hFF0001);
        chk("min_sclk_per", fall_per, 2);
        chk("min_done_cyc", done_cyc, 51);
        chk("min_idle_cyc", idle_cyc, 52);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1);
    end
endmodule
